ft245r_cmd_rx: RTL and testbench

- Host-to-device command path over the FT245R parallel FIFO; the read-side counterpart of the existing ADC-to-USB write path.
- Pulls bytes from the FTDI receive FIFO with RD# strobes and parses fixed-length command frames.
- Drives the ADC configuration pins, status LEDs, ADC run/reset and stream-enable controls, which are otherwise tied static at top level.
- Shares usb_bus with the write engine, so it only reads while the writer reports idle.

---
 rtl/ft245r_cmd_rx.sv | 241 ++++++++++++++++++++++++
 tb/tb_ft245r_cmd_rx.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ft245r_cmd_rx.sv
// ----------------------------------------------------------------------------
// ft245r_cmd_rx
//
// Host-to-device command receiver for the FT245R parallel FIFO. Pulls bytes
// from the FTDI receive FIFO with RD# strobes. This happens only while the
// write engine reports idle. The bytes are parsed as fixed-length frames:
//   SYNC_BYTE, addr, data [, cksum]
// Each committed frame updates one of the control registers below.
//
// Optional feature (macro CMD_CKSUM_EN):
//   When defined, frames carry a fourth byte equal to SYNC_BYTE^addr^data.
//   A frame whose checksum does not match is dropped and counted as an error.
//
// Ports:
//   clk        in   master clock (mclk domain)
//   reset_     in   asynchronous active-low reset
//   usb_rxf_   in   FTDI receive-data-available, active low, asynchronous
//   usb_data   in   usb_bus value, sampled on the last RD# low cycle
//   wr_idle    in   write engine is not driving usb_bus
//   usb_rd_    out  FTDI read strobe, active low (registered, glitch-free)
//   rd_busy    out  read in progress (RD# low or inter-read gap)
//   adc_cfg    out  {m1,m0,lj_,hpf_,mdiv,m_s_}           (addr 0x00)
//   status     out  LED register                         (addr 0x01)
//   adc_run    out  drives adc_reset_, 1 = release ADC   (addr 0x02 bit 0)
//   stream_en  out  enables the ADC-to-USB stream        (addr 0x02 bit 1)
//   cmd_strobe out  1-cycle pulse on each committed write
//   cmd_err    out  1-cycle pulse on bad address, timeout or checksum error
//   err_count  out  saturating error counter
// ----------------------------------------------------------------------------
module ft245r_cmd_rx #(
   parameter int unsigned RD_LOW_CYCLES  = 3,
   parameter int unsigned RD_GAP_CYCLES  = 2,
   parameter int unsigned TIMEOUT_CYCLES = 65535,
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
   input  logic       clk,
   input  logic       reset_,
   input  logic       usb_rxf_,
   input  logic [7:0] usb_data,
   input  logic       wr_idle,
   output logic       usb_rd_,
   output logic       rd_busy,
   output logic [5:0] adc_cfg,
   output logic [7:0] status,
   output logic       adc_run,
   output logic       stream_en,
   output logic       cmd_strobe,
   output logic       cmd_err,
   output logic [7:0] err_count
);

   localparam logic [7:0] LOW_LAST = 8'(RD_LOW_CYCLES - 1);
   localparam logic [7:0] GAP_LAST = 8'(RD_GAP_CYCLES - 1);
   localparam int unsigned TO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {R_IDLE, R_LOW, R_GAP} rd_state_t;
`ifdef CMD_CKSUM_EN
   typedef enum logic [1:0] {F_SYNC, F_ADDR, F_DATA, F_CKSUM} fr_state_t;
`else
   typedef enum logic [1:0] {F_SYNC, F_ADDR, F_DATA} fr_state_t;
`endif

   // -------------------------------------------------------------------------
   // usb_rxf_ synchronizer
   // -------------------------------------------------------------------------
   logic rxf_meta, rxf_sync;

   // NOTE: state elements use non-blocking assignments so every flop samples
   // the pre-edge value; blocking here would collapse the two sync stages.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         rxf_meta <= 1'b1;
         rxf_sync <= 1'b1;
      end else begin
         rxf_meta <= usb_rxf_;
         rxf_sync <= rxf_meta;
      end
   end

   // -------------------------------------------------------------------------
   // Read FSM: one RD# pulse per byte, then a gap long enough for RXF# to
   // rise and propagate through the synchronizer.
   // -------------------------------------------------------------------------
   rd_state_t  rd_state, rd_nxt;
   logic [7:0] rd_cnt, rd_cnt_nxt;
   logic       take;
   logic       byte_valid;
   logic [7:0] rx_byte;

   // NOTE: every combinational output gets a default before the case so no
   // path leaves it unassigned, which would infer a latch.
   always_comb begin
      rd_nxt     = rd_state;
      rd_cnt_nxt = rd_cnt;
      take       = 1'b0;
      case (rd_state)
         R_IDLE: if (!rxf_sync && wr_idle) begin
            rd_nxt     = R_LOW;
            rd_cnt_nxt = '0;
         end
         R_LOW: if (rd_cnt == LOW_LAST) begin
            take       = 1'b1;
            rd_nxt     = R_GAP;
            rd_cnt_nxt = '0;
         end else begin
            rd_cnt_nxt = rd_cnt + 8'd1;
         end
         R_GAP: if (rd_cnt == GAP_LAST) begin
            rd_nxt = R_IDLE;
         end else begin
            rd_cnt_nxt = rd_cnt + 8'd1;
         end
         default: rd_nxt = R_IDLE;
      endcase
   end

   // usb_rd_/rd_busy are registered from the next state so the FTDI sees a
   // clean strobe; async reset still forces RD# high immediately.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         rd_state   <= R_IDLE;
         rd_cnt     <= '0;
         usb_rd_    <= 1'b1;
         rd_busy    <= 1'b0;
         byte_valid <= 1'b0;
         rx_byte    <= '0;
      end else begin
         rd_state   <= rd_nxt;
         rd_cnt     <= rd_cnt_nxt;
         usb_rd_    <= (rd_nxt != R_LOW);
         rd_busy    <= (rd_nxt != R_IDLE);
         byte_valid <= take;
         if (take) rx_byte <= usb_data;
      end
   end

   // -------------------------------------------------------------------------
   // Frame FSM and timeout
   // -------------------------------------------------------------------------
   fr_state_t       f_state, f_nxt;
   logic [7:0]      addr_q;
   logic [TO_W-1:0] to_cnt;
   logic            latch_addr, commit, bad, timeout;
   logic            addr_ok, do_strobe, do_err;
   logic [7:0]      cmd_data;

`ifdef CMD_CKSUM_EN
   logic [7:0] data_q;
   logic       latch_data;
   assign cmd_data = data_q;
`else
   // Without a checksum the data byte itself triggers the commit.
   assign cmd_data = rx_byte;
`endif

   always_comb begin
      f_nxt      = f_state;
      latch_addr = 1'b0;
      commit     = 1'b0;
      bad        = 1'b0;
`ifdef CMD_CKSUM_EN
      latch_data = 1'b0;
`endif
      timeout    = (f_state != F_SYNC) && !byte_valid && (to_cnt == TO_LAST);
      if (byte_valid) begin
         case (f_state)
            F_SYNC: if (rx_byte == SYNC_BYTE) f_nxt = F_ADDR;
            F_ADDR: begin
               latch_addr = 1'b1;
               f_nxt      = F_DATA;
            end
            F_DATA: begin
`ifdef CMD_CKSUM_EN
               latch_data = 1'b1;
               f_nxt      = F_CKSUM;
`else
               commit     = 1'b1;
               f_nxt      = F_SYNC;
`endif
            end
`ifdef CMD_CKSUM_EN
            F_CKSUM: begin
               f_nxt = F_SYNC;
               if (rx_byte == (SYNC_BYTE ^ addr_q ^ data_q)) commit = 1'b1;
               else                                          bad    = 1'b1;
            end
`endif
            default: f_nxt = F_SYNC;
         endcase
      end else if (timeout) begin
         f_nxt = F_SYNC;
         bad   = 1'b1;
      end
   end

   assign addr_ok   = (addr_q <= 8'h02);
   assign do_strobe = commit && addr_ok;
   assign do_err    = bad || (commit && !addr_ok);

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         f_state    <= F_SYNC;
         addr_q     <= '0;
         to_cnt     <= '0;
         adc_cfg    <= '0;
         status     <= 8'hFF;
         adc_run    <= 1'b0;
         stream_en  <= 1'b0;
         cmd_strobe <= 1'b0;
         cmd_err    <= 1'b0;
         err_count  <= '0;
`ifdef CMD_CKSUM_EN
         data_q     <= '0;
`endif
      end else begin
         f_state    <= f_nxt;
         cmd_strobe <= do_strobe;
         cmd_err    <= do_err;
         if (latch_addr) addr_q <= rx_byte;
`ifdef CMD_CKSUM_EN
         if (latch_data) data_q <= rx_byte;
`endif
         // Counts idle cycles inside a partial frame only.
         if (byte_valid || f_state == F_SYNC || timeout) to_cnt <= '0;
         else                                             to_cnt <= to_cnt + 1'b1;
         if (do_strobe) begin
            case (addr_q)
               8'h00:   adc_cfg <= cmd_data[5:0];
               8'h01:   status  <= cmd_data;
               default: begin
                  adc_run   <= cmd_data[0];
                  stream_en <= cmd_data[1];
               end
            endcase
         end
         if (do_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_ft245r_cmd_rx.sv
// ----------------------------------------------------------------------------
// tb_ft245r_cmd_rx
//
// Self-checking bench for ft245r_cmd_rx. Emulates the FTDI receive FIFO,
// feeds directed and random frames, and compares the DUT registers and
// pulse counts against a byte-stream reference model. Define CMD_CKSUM_EN
// for both bench and RTL to exercise the 4-byte frame format.
// ----------------------------------------------------------------------------
module tb_ft245r_cmd_rx;

   localparam logic [7:0] SYNC = 8'hA5;
`ifdef CMD_CKSUM_EN
   localparam int FRAME_LEN = 4;
`else
   localparam int FRAME_LEN = 3;
`endif

   logic       clk = 1'b0;
   logic       reset_ = 1'b0;
   logic       usb_rxf_ = 1'b1;
   logic [7:0] usb_data = 8'h00;
   logic       wr_idle = 1'b1;
   logic       usb_rd_, rd_busy, adc_run, stream_en, cmd_strobe, cmd_err;
   logic [5:0] adc_cfg;
   logic [7:0] status, err_count;

   always #5 clk = ~clk;

   ft245r_cmd_rx dut (
      .clk        (clk),
      .reset_     (reset_),
      .usb_rxf_   (usb_rxf_),
      .usb_data   (usb_data),
      .wr_idle    (wr_idle),
      .usb_rd_    (usb_rd_),
      .rd_busy    (rd_busy),
      .adc_cfg    (adc_cfg),
      .status     (status),
      .adc_run    (adc_run),
      .stream_en  (stream_en),
      .cmd_strobe (cmd_strobe),
      .cmd_err    (cmd_err),
      .err_count  (err_count)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ------------------------------------------------------------------------
   // Bus monitor: RD# pulse widths, inter-read gaps, read and pulse counts.
   // ------------------------------------------------------------------------
   int low_cnt = 0, high_cnt = 0, reads = 0, rd_viol = 0, strobes = 0, errs = 0;
   bit seen_rise = 1'b0;

   always @(negedge clk) begin
      if (!reset_) begin
         low_cnt   = 0;
         high_cnt  = 0;
         seen_rise = 1'b0;
      end else if (!usb_rd_) begin
         if (low_cnt == 0) begin
            reads++;
            if (seen_rise && high_cnt < 2) rd_viol++;
         end
         low_cnt++;
      end else begin
         if (low_cnt != 0) begin
            if (low_cnt != 3) rd_viol++;
            low_cnt   = 0;
            high_cnt  = 0;
            seen_rise = 1'b1;
         end
         high_cnt++;
      end
      if (cmd_strobe) strobes++;
      if (cmd_err)    errs++;
   end

   // ------------------------------------------------------------------------
   // Reference model: a frame is SYNC followed by FRAME_LEN-1 bytes taken
   // verbatim; anything else outside a frame is ignored.
   // ------------------------------------------------------------------------
   logic [5:0] m_cfg;
   logic [7:0] m_status;
   logic       m_run, m_stream;
   int         m_errcnt, m_err_total = 0, m_strobe_total = 0, m_reads = 0;
   logic [7:0] pend[$];

   function automatic void model_reset();
      m_cfg = '0; m_status = 8'hFF; m_run = 1'b0; m_stream = 1'b0;
      m_errcnt = 0;
      pend.delete();
   endfunction

   function automatic void model_err();
      m_err_total++;
      if (m_errcnt < 255) m_errcnt++;
   endfunction

   function automatic void model_byte(input logic [7:0] b);
      logic [7:0] a, d;
      bit ok;
      if (pend.size() == 0 && b != SYNC) return;
      pend.push_back(b);
      if (pend.size() == FRAME_LEN) begin
         a  = pend[1];
         d  = pend[2];
         ok = 1'b1;
         if (pend.size() == 4 && pend[3] != (SYNC ^ a ^ d)) ok = 1'b0;
         pend.delete();
         if (!ok)            model_err();
         else if (a == 8'h00) begin m_cfg = d[5:0]; m_strobe_total++; end
         else if (a == 8'h01) begin m_status = d;   m_strobe_total++; end
         else if (a == 8'h02) begin m_run = d[0]; m_stream = d[1]; m_strobe_total++; end
         else                model_err();
      end
   endfunction

   function automatic void model_timeout();
      if (pend.size() != 0) begin
         pend.delete();
         model_err();
      end
   endfunction

   // ------------------------------------------------------------------------
   // FIFO emulation
   // ------------------------------------------------------------------------
   task automatic send_byte(input logic [7:0] b);
      int n;
      usb_data = 8'($urandom);   // bus is not valid until RD# falls
      usb_rxf_ = 1'b0;
      n = 0;
      while (usb_rd_ && n < 40) begin @(negedge clk); n++; end
      chk("rd_fall", usb_rd_, 1'b0);
      if (usb_rd_) begin usb_rxf_ = 1'b1; return; end
      usb_data = b;
      chk("rd_busy", rd_busy, 1'b1);
      n = 0;
      while (!usb_rd_ && n < 10) begin @(negedge clk); n++; end
      chk("rd_rise", usb_rd_, 1'b1);
      usb_rxf_ = 1'b1;
      usb_data = 8'($urandom);
      model_byte(b);
      m_reads++;
      @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] corrupt);
      send_byte(SYNC);
      send_byte(a);
      send_byte(d);
`ifdef CMD_CKSUM_EN
      send_byte(SYNC ^ a ^ d ^ corrupt);
`else
      if (corrupt != 8'h00) send_byte(8'h00);   // trailing byte, dropped while hunting for sync
`endif
   endtask

   task automatic check_regs(input string tag);
      repeat (4) @(negedge clk);
      chk({tag, ":adc_cfg"},   adc_cfg,   m_cfg);
      chk({tag, ":status"},    status,    m_status);
      chk({tag, ":adc_run"},   adc_run,   m_run);
      chk({tag, ":stream_en"}, stream_en, m_stream);
      chk({tag, ":err_count"}, err_count, m_errcnt);
      chk({tag, ":strobes"},   strobes,   m_strobe_total);
      chk({tag, ":errs"},      errs,      m_err_total);
      chk({tag, ":reads"},     reads,     m_reads);
      chk({tag, ":rd_timing"}, rd_viol,   0);
   endtask

   task automatic apply_reset();
      reset_   = 1'b0;
      usb_rxf_ = 1'b1;
      repeat (3) @(negedge clk);
      reset_ = 1'b1;
      model_reset();
      @(negedge clk);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bit low_seen;
      logic [7:0] a, d, j, c;

      // Reset state
      apply_reset();
      chk("rst:usb_rd_",    usb_rd_,    1'b1);
      chk("rst:rd_busy",    rd_busy,    1'b0);
      chk("rst:adc_cfg",    adc_cfg,    6'h00);
      chk("rst:status",     status,     8'hFF);
      chk("rst:adc_run",    adc_run,    1'b0);
      chk("rst:stream_en",  stream_en,  1'b0);
      chk("rst:cmd_strobe", cmd_strobe, 1'b0);
      chk("rst:cmd_err",    cmd_err,    1'b0);
      chk("rst:err_count",  err_count,  8'h00);

      // A5 00 2D
      send_frame(8'h00, 8'h2D, 8'h00);
      check_regs("cfg");
      chk("cfg:value", adc_cfg, 6'h2D);
      chk("cfg:strobe_once", strobes, 1);

      // 11 A5 01 5A: leading junk dropped silently
      send_byte(8'h11);
      send_frame(8'h01, 8'h5A, 8'h00);
      check_regs("status");
      chk("status:value", status, 8'h5A);
      chk("status:no_err", errs, 0);

      // A5 07 FF: bad address
      send_frame(8'h07, 8'hFF, 8'h00);
      check_regs("badaddr");
      chk("badaddr:err_count", err_count, 8'h01);

      // Partial frame then timeout
      apply_reset();
      send_byte(SYNC);
      send_byte(8'h02);
      repeat (65535 - 40) @(negedge clk);
      chk("timeout:early", errs, m_err_total);
      repeat (120) @(negedge clk);
      model_timeout();
      check_regs("timeout");
      chk("timeout:err_count", err_count, 8'h01);
      send_frame(8'h02, 8'h03, 8'h00);
      check_regs("run");
      chk("run:adc_run", adc_run, 1'b1);
      chk("run:stream_en", stream_en, 1'b1);

      // wr_idle gating, and wr_idle dropping mid-read has no effect
      wr_idle  = 1'b0;
      usb_rxf_ = 1'b0;
      low_seen = 1'b0;
      repeat (20) begin @(negedge clk); if (!usb_rd_) low_seen = 1'b1; end
      chk("wr_idle:hold", low_seen, 1'b0);
      wr_idle = 1'b1;
      n = 0;
      while (usb_rd_ && n < 3) begin @(negedge clk); n++; end
      chk("wr_idle:resume", usb_rd_, 1'b0);
      usb_data = SYNC;
      wr_idle  = 1'b0;
      n = 0;
      while (!usb_rd_ && n < 10) begin @(negedge clk); n++; end
      chk("wr_idle:complete", usb_rd_, 1'b1);
      usb_rxf_ = 1'b1;
      wr_idle  = 1'b1;
      model_byte(SYNC);
      m_reads++;
      @(negedge clk);
      send_byte(8'h01);
      send_byte(8'h77);
`ifdef CMD_CKSUM_EN
      send_byte(SYNC ^ 8'h01 ^ 8'h77);
`endif
      check_regs("wr_idle");

      // Random frames
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            j = 8'($urandom);
            if (j == SYNC) j = 8'h00;
            send_byte(j);
         end
         case ($urandom_range(0, 3))
            0:       a = 8'h00;
            1:       a = 8'h01;
            2:       a = 8'h02;
            default: a = 8'($urandom_range(3, 255));
         endcase
         d = 8'($urandom);
         c = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
         send_frame(a, d, c);
         check_regs("rand");
      end

`ifdef CMD_CKSUM_EN
      send_frame(8'h01, 8'h3C, 8'h00);
      check_regs("cksum_ok");
      chk("cksum_ok:status", status, 8'h3C);
      n = errs;
      send_byte(SYNC);
      send_byte(8'h01);
      send_byte(8'h3C);
      send_byte(8'h00);
      check_regs("cksum_bad");
      chk("cksum_bad:status", status, 8'h3C);
      chk("cksum_bad:err_pulse", errs, n + 1);
`endif

      // Async reset in the middle of RD# low
      send_byte(SYNC);
      usb_rxf_ = 1'b0;
      n = 0;
      while (usb_rd_ && n < 40) begin @(negedge clk); n++; end
      chk("midrst:rd_fall", usb_rd_, 1'b0);
      m_reads++;
      #1 reset_ = 1'b0;
      #1;
      chk("midrst:usb_rd_",   usb_rd_,   1'b1);
      chk("midrst:rd_busy",   rd_busy,   1'b0);
      chk("midrst:adc_cfg",   adc_cfg,   6'h00);
      chk("midrst:status",    status,    8'hFF);
      chk("midrst:adc_run",   adc_run,   1'b0);
      chk("midrst:stream_en", stream_en, 1'b0);
      chk("midrst:err_count", err_count, 8'h00);
      usb_rxf_ = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      reset_ = 1'b1;
      @(negedge clk);
      send_frame(8'h00, 8'h15, 8'h00);
      check_regs("after_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
